// File: rtl/until_monitor_pkg.sv
// Shared types for the until_monitor assertion checker: channel FSM state,
// attempt result encoding and the tick-counter width helper.
package until_monitor_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_PASS = 2'd1,
        RES_FAIL = 2'd2
    } result_e;

    function automatic int tick_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/until_monitor_chan.sv
// One channel of the until monitor: evaluates "lhs until rhs" per attempt,
// resolving on rhs, on lhs dropping, on timeout, or on abort.
module until_monitor_chan
    import until_monitor_pkg::*;
#(
    parameter int STRONG  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic lhs,
    input  logic rhs,
    input  logic abort,
    output logic busy,
    output logic pass,
    output logic fail,
    output logic tmo
);

    localparam int            TW        = tick_w(TIMEOUT);
    localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT);
    // An unresolved attempt counts as failed under s_until, passed under weak until.
    localparam result_e       RES_TMO   = (STRONG != 0) ? RES_FAIL : RES_PASS;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d, tick_inc;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          tmo_q, tmo_d;
    result_e       res;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        tmo_d    = 1'b0;
        res      = RES_NONE;
        tick_inc = tick_q + TW'(1);
        if (state_q == ST_ACTIVE && abort) begin
            res     = RES_TMO;
            state_d = ST_IDLE;
            tick_d  = '0;
        end else if (!abort && (state_q == ST_ACTIVE || arm)) begin
            if (rhs) begin
                res     = RES_PASS;
                state_d = ST_IDLE;
                tick_d  = '0;
            end else if (!lhs) begin
                res     = RES_FAIL;
                state_d = ST_IDLE;
                tick_d  = '0;
            end else if (tick_inc == TICK_LAST) begin
                res     = RES_TMO;
                tmo_d   = 1'b1;
                state_d = ST_IDLE;
                tick_d  = '0;
            end else begin
                state_d = ST_ACTIVE;
                tick_d  = tick_inc;
            end
        end
        pass_d = (res == RES_PASS);
        fail_d = (res == RES_FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy = (state_q == ST_ACTIVE);
    assign pass = pass_q;
    assign fail = fail_q;
    assign tmo  = tmo_q;

endmodule

// File: rtl/until_monitor.sv
// Multi-channel until monitor. Optional saturating pass/fail statistics are
// built only when UNTIL_MONITOR_STATS_EN is defined; otherwise the counts read 0.
module until_monitor
    import until_monitor_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int STRONG  = 1,
    parameter int TIMEOUT = 16,
    parameter int CW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] arm,
    input  logic [NCH-1:0] lhs,
    input  logic [NCH-1:0] rhs,
    input  logic           abort,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] pass,
    output logic [NCH-1:0] fail,
    output logic [NCH-1:0] tmo,
    output logic [CW-1:0]  pass_cnt,
    output logic [CW-1:0]  fail_cnt
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        until_monitor_chan #(
            .STRONG  (STRONG),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .arm   (arm[g]),
            .lhs   (lhs[g]),
            .rhs   (rhs[g]),
            .abort (abort),
            .busy  (busy[g]),
            .pass  (pass[g]),
            .fail  (fail[g]),
            .tmo   (tmo[g])
        );
    end

`ifdef UNTIL_MONITOR_STATS_EN
    // Six spare bits hold up to 32 pulses per cycle before the saturation test.
    localparam int            SW      = CW + 6;
    localparam logic [SW-1:0] CNT_MAX = {6'b0, {CW{1'b1}}};

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c, input logic [NCH-1:0] v);
        logic [SW-1:0] s;
        s = SW'(c) + SW'($countones(v));
        return (s > CNT_MAX) ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic [CW-1:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        pass_cnt_d = sat_add(pass_cnt_q, pass);
        fail_cnt_d = sat_add(fail_cnt_q, fail);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_until_monitor.sv
// Bench for until_monitor: strong and weak instances share stimulus; a
// per-channel attempt model is compared every cycle, plus literal spot checks.
module tb_until_monitor;

    localparam int NCH = 4;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int CMAX = 15;
`ifdef UNTIL_MONITOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] arm = '0, lhs = '0, rhs = '0;
    logic           abort = 1'b0;
    logic [NCH-1:0] busy1, pass1, fail1, tmo1;
    logic [NCH-1:0] busy0, pass0, fail0, tmo0;
    logic [CW-1:0]  pc1, fc1, pc0, fc0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    until_monitor #(.NCH(NCH), .STRONG(1), .TIMEOUT(TO), .CW(CW)) dut_s (
        .clk(clk), .rst(rst), .arm(arm), .lhs(lhs), .rhs(rhs), .abort(abort),
        .busy(busy1), .pass(pass1), .fail(fail1), .tmo(tmo1),
        .pass_cnt(pc1), .fail_cnt(fc1));

    until_monitor #(.NCH(NCH), .STRONG(0), .TIMEOUT(TO), .CW(CW)) dut_w (
        .clk(clk), .rst(rst), .arm(arm), .lhs(lhs), .rhs(rhs), .abort(abort),
        .busy(busy0), .pass(pass0), .fail(fail0), .tmo(tmo0),
        .pass_cnt(pc0), .fail_cnt(fc0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel holds an attempt (active flag + edges survived).
    // Outcome codes: 0 none, 1 rhs seen, 2 lhs dropped, 3 timeout, 4 abort.
    bit             m_act [NCH];
    int             m_tick[NCH];
    int             oc;
    bit             go;
    logic [NCH-1:0] e_busy, e_tmo, e_pass1, e_fail1, e_pass0, e_fail0;
    int             e_pc1, e_fc1, e_pc0, e_fc0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_act[c]  = 1'b0;
                m_tick[c] = 0;
            end
            {e_busy, e_tmo, e_pass1, e_fail1, e_pass0, e_fail0} = '0;
            e_pc1 = 0; e_fc1 = 0; e_pc0 = 0; e_fc0 = 0;
        end else begin
            e_pc1 = sat(e_pc1 + $countones(e_pass1));
            e_fc1 = sat(e_fc1 + $countones(e_fail1));
            e_pc0 = sat(e_pc0 + $countones(e_pass0));
            e_fc0 = sat(e_fc0 + $countones(e_fail0));
            for (int c = 0; c < NCH; c++) begin
                oc = 0;
                go = m_act[c] || (arm[c] && !abort);
                if (!m_act[c]) m_tick[c] = 0;
                if (m_act[c] && abort) oc = 4;
                else if (go) begin
                    if (rhs[c]) oc = 1;
                    else if (!lhs[c]) oc = 2;
                    else begin
                        m_tick[c] = m_tick[c] + 1;
                        if (m_tick[c] == TO) oc = 3;
                    end
                end
                m_act[c]   = go && (oc == 0);
                e_busy[c]  = m_act[c];
                e_tmo[c]   = (oc == 3);
                e_pass1[c] = (oc == 1);
                e_fail1[c] = (oc == 2) || (oc >= 3);
                e_pass0[c] = (oc == 1) || (oc >= 3);
                e_fail0[c] = (oc == 2);
            end
        end
    end

    always @(negedge clk) begin
        check("busy_s", 32'(busy1), 32'(e_busy));
        check("pass_s", 32'(pass1), 32'(e_pass1));
        check("fail_s", 32'(fail1), 32'(e_fail1));
        check("tmo_s",  32'(tmo1),  32'(e_tmo));
        check("busy_w", 32'(busy0), 32'(e_busy));
        check("pass_w", 32'(pass0), 32'(e_pass0));
        check("fail_w", 32'(fail0), 32'(e_fail0));
        check("tmo_w",  32'(tmo0),  32'(e_tmo));
        check("pcnt_s", 32'(pc1), STATS ? 32'(e_pc1) : 32'd0);
        check("fcnt_s", 32'(fc1), STATS ? 32'(e_fc1) : 32'd0);
        check("pcnt_w", 32'(pc0), STATS ? 32'(e_pc0) : 32'd0);
        check("fcnt_w", 32'(fc0), STATS ? 32'(e_fc0) : 32'd0);
    end

    // Drive one edge's inputs at a falling edge and advance to the next one.
    task automatic cyc(input logic [NCH-1:0] a, input logic [NCH-1:0] l,
                       input logic [NCH-1:0] r, input logic ab);
        arm = a; lhs = l; rhs = r; abort = ab;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_pcnt", 32'(pc1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Held lhs on ch0 until timeout; re-arms while active are ignored.
        cyc(4'b0001, 4'b0001, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0001, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0001, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0001, 4'b0000, 1'b0);
        repeat (3) cyc(4'b0000, 4'b0001, 4'b0000, 1'b0);
        check("lit_busy_e7", 32'(busy1[0]), 32'd1);
        cyc(4'b0001, 4'b0001, 4'b0000, 1'b0);
        check("lit_fail_s_e8", 32'(fail1[0]), 32'd1);
        check("lit_tmo_s_e8",  32'(tmo1[0]),  32'd1);
        check("lit_pass_w_e8", 32'(pass0[0]), 32'd1);
        check("lit_tmo_w_e8",  32'(tmo0[0]),  32'd1);
        check("lit_fail_w_e8", 32'(fail0[0]), 32'd0);
        check("lit_busy_e8",   32'(busy1[0]), 32'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("lit_fail_s_e9", 32'(fail1[0]), 32'd0);

        // Immediate pass on ch1, re-arm on the next edge, then lhs drop.
        cyc(4'b0010, 4'b0000, 4'b0010, 1'b0);
        check("lit_pass_imm", 32'(pass1), 32'b0010);
        check("lit_busy_imm", 32'(busy1), 32'd0);
        cyc(4'b0010, 4'b0010, 4'b0000, 1'b0);
        check("lit_rearm", 32'(busy1[1]), 32'd1);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("lit_fail_ch1", 32'(fail0[1]), 32'd1);
        cyc(4'b0100, 4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("lit_fail_ch2_s", 32'(fail1), 32'b0100);
        check("lit_fail_ch2_w", 32'(fail0), 32'b0100);

        // Abort at edge 5 with a concurrent arm (rhs=1) on ch1.
        cyc(4'b1001, 4'b1001, 4'b0000, 1'b0);
        repeat (3) cyc(4'b0000, 4'b1001, 4'b0000, 1'b0);
        cyc(4'b0010, 4'b1011, 4'b0010, 1'b1);
        check("lit_abort_fail_s", 32'(fail1), 32'b1001);
        check("lit_abort_pass_s", 32'(pass1), 32'd0);
        check("lit_abort_tmo_s",  32'(tmo1),  32'd0);
        check("lit_abort_pass_w", 32'(pass0), 32'b1001);
        check("lit_abort_tmo_w",  32'(tmo0),  32'd0);
        check("lit_abort_busy",   32'(busy1), 32'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset between edges mid-attempt.
        cyc(4'b0001, 4'b0001, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0001, 4'b0000, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("lit_rst_busy_s", 32'(busy1), 32'd0);
        check("lit_rst_busy_w", 32'(busy0), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("lit_rst_nopulse", 32'({pass1, fail1, pass0, fail0}), 32'd0);

        // 20 passes per instance; counter saturates at 15 when stats are built.
        repeat (5) cyc(4'b1111, 4'b0000, 4'b1111, 1'b0);
        repeat (2) cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("lit_pcnt_sat_s", 32'(pc1), STATS ? 32'd15 : 32'd0);
        check("lit_pcnt_sat_w", 32'(pc0), STATS ? 32'd15 : 32'd0);
        check("lit_fcnt_s",     32'(fc1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
